// File: rtl/nor_gate_unit.sv
// Registered bitwise NOR with valid qualifier, all-ones detect and saturating hit counter.
// Define NOR_GATE_UNIT_COMB_OUT_EN to make y/y_all/out_valid combinational (hit_cnt stays registered).
module nor_gate_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic             y_all,
    output logic [CNT_W-1:0] hit_cnt
);

    // Handshake: in_valid qualifies a/b on the rising edge; there is no ready,
    // so every valid cycle is accepted and out_valid pulses once per accepted vector.
    logic [WIDTH-1:0] nor_w;
    logic             all_zero;
    logic             hit;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    assign nor_w    = ~(a | b);
    assign all_zero = ((a | b) == '0);
    assign hit      = in_valid && all_zero;

`ifdef NOR_GATE_UNIT_COMB_OUT_EN
    assign y         = nor_w;
    assign y_all     = all_zero;
    assign out_valid = in_valid;
`else
    // y resets to 0 rather than NOR(0,0) so a reset output never looks like a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            y_all     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y     <= nor_w;
                y_all <= all_zero;
            end
        end
    end
`endif

    // Clear wins over a simultaneous hit; the count saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (clr_cnt) begin
            hit_cnt <= '0;
        end else if (hit && (hit_cnt != CNT_MAX)) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_nor_gate_unit.sv
// Directed self-checking bench for nor_gate_unit: a WIDTH=1/CNT_W=16 and a WIDTH=8/CNT_W=2 instance.
module tb_nor_gate_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        clr_cnt;
    logic        a1, b1, y1, ov1, yall1;
    logic [15:0] cnt1;
    logic [7:0]  a8, b8, y8;
    logic        ov8, yall8;
    logic [1:0]  cnt8;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_cnt1;

    nor_gate_unit #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .y(y1), .out_valid(ov1), .y_all(yall1), .hit_cnt(cnt1)
    );

    nor_gate_unit #(.WIDTH(8), .CNT_W(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .y(y8), .out_valid(ov8), .y_all(yall8), .hit_cnt(cnt8)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; inputs change and outputs are sampled 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        exp_cnt1 = '0;
        repeat (3) step();
        n_checks++; if ({y1, yall1, ov1, cnt1} !== 19'd0) $display("FAIL reset_dut1: got y=%b y_all=%b ov=%b cnt=%0d, want all 0", y1, yall1, ov1, cnt1); else n_pass++;
        n_checks++; if ({y8, yall8, ov8, cnt8} !== 12'd0) $display("FAIL reset_dut8: got y=%h y_all=%b ov=%b cnt=%0d, want all 0", y8, yall8, ov8, cnt8); else n_pass++;
        #2 rst_n = 1'b1;
        step();
    endtask

`ifndef NOR_GATE_UNIT_COMB_OUT_EN
    task automatic test_truth_table();
        logic [1:0] ab_vec [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic       y_exp  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = ab_vec[i];
            step();
            n_checks++; if (y1 !== y_exp[i] || yall1 !== y_exp[i]) $display("FAIL truth_%0d: got y=%b y_all=%b, want %b", i, y1, yall1, y_exp[i]); else n_pass++;
            n_checks++; if (ov1 !== 1'b1) $display("FAIL truth_valid_%0d: got out_valid=%b, want 1", i, ov1); else n_pass++;
        end
        exp_cnt1 = 16'd1;
        n_checks++; if (cnt1 !== exp_cnt1) $display("FAIL truth_cnt: got hit_cnt=%0d, want %0d", cnt1, exp_cnt1); else n_pass++;
        in_valid = 1'b0; a1 = 1'b1; b1 = 1'b1;
        step();
        n_checks++; if (ov1 !== 1'b0) $display("FAIL truth_valid_drop: got out_valid=%b, want 0", ov1); else n_pass++;
    endtask

    task automatic test_multibit();
        in_valid = 1'b1; a8 = 8'hF0; b8 = 8'h0C;
        step();
        n_checks++; if (y8 !== 8'h03 || yall8 !== 1'b0) $display("FAIL multibit_f0_0c: got y=%h y_all=%b, want 03 0", y8, yall8); else n_pass++;
        a8 = 8'h00; b8 = 8'h00;
        step();
        n_checks++; if (y8 !== 8'hFF || yall8 !== 1'b1 || ov8 !== 1'b1) $display("FAIL multibit_zero: got y=%h y_all=%b ov=%b, want ff 1 1", y8, yall8, ov8); else n_pass++;
        n_checks++; if (cnt8 !== 2'd1) $display("FAIL multibit_cnt: got hit_cnt=%0d, want 1", cnt8); else n_pass++;
        in_valid = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        step();
    endtask

    task automatic test_saturation();
        logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        n_checks++; if (cnt8 !== 2'd0) $display("FAIL sat_clear_idle: got hit_cnt=%0d, want 0", cnt8); else n_pass++;
        in_valid = 1'b1; a8 = 8'h00; b8 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (cnt8 !== cnt_exp[i]) $display("FAIL sat_%0d: got hit_cnt=%0d, want %0d", i, cnt8, cnt_exp[i]); else n_pass++;
        end
        clr_cnt = 1'b1;
        step();
        n_checks++; if (cnt8 !== 2'd0) $display("FAIL sat_clear_wins: got hit_cnt=%0d, want 0", cnt8); else n_pass++;
        clr_cnt = 1'b0; in_valid = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        exp_cnt1 = '0;
        step();
    endtask

    task automatic test_hold();
        in_valid = 1'b1; a1 = 1'b0; b1 = 1'b0;
        step();
        exp_cnt1 = exp_cnt1 + 16'd1;
        n_checks++; if (y1 !== 1'b1 || cnt1 !== exp_cnt1) $display("FAIL hold_accept: got y=%b cnt=%0d, want 1 %0d", y1, cnt1, exp_cnt1); else n_pass++;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = ~a1; b1 = ~b1;
            step();
            n_checks++; if (y1 !== 1'b1 || yall1 !== 1'b1 || ov1 !== 1'b0) $display("FAIL hold_%0d: got y=%b y_all=%b ov=%b, want 1 1 0", i, y1, yall1, ov1); else n_pass++;
            n_checks++; if (cnt1 !== exp_cnt1) $display("FAIL hold_cnt_%0d: got hit_cnt=%0d, want %0d", i, cnt1, exp_cnt1); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({y1, yall1, ov1, cnt1} !== 19'd0) $display("FAIL async_reset_dut1: got y=%b y_all=%b ov=%b cnt=%0d, want all 0", y1, yall1, ov1, cnt1); else n_pass++;
        n_checks++; if ({y8, yall8, ov8, cnt8} !== 12'd0) $display("FAIL async_reset_dut8: got y=%h y_all=%b ov=%b cnt=%0d, want all 0", y8, yall8, ov8, cnt8); else n_pass++;
        in_valid = 1'b1; a1 = 1'b0; b1 = 1'b0;
        step();
        n_checks++; if (ov1 !== 1'b0 || y1 !== 1'b0 || cnt1 !== 16'd0) $display("FAIL reset_discard: got ov=%b y=%b cnt=%0d, want 0 0 0", ov1, y1, cnt1); else n_pass++;
        #2 rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        step();
        n_checks++; if (y1 !== 1'b0 || ov1 !== 1'b1) $display("FAIL post_reset_11: got y=%b ov=%b, want 0 1", y1, ov1); else n_pass++;
        in_valid = 1'b0;
        step();
    endtask
`else
    task automatic test_comb_out();
        in_valid = 1'b0; a1 = 1'b1; b1 = 1'b0;
        #1;
        n_checks++; if (y1 !== 1'b0 || ov1 !== 1'b0) $display("FAIL comb_initial: got y=%b ov=%b, want 0 0", y1, ov1); else n_pass++;
        a1 = 1'b0; in_valid = 1'b1;
        #1;
        n_checks++; if (y1 !== 1'b1 || yall1 !== 1'b1 || ov1 !== 1'b1) $display("FAIL comb_no_edge: got y=%b y_all=%b ov=%b, want 1 1 1", y1, yall1, ov1); else n_pass++;
        a8 = 8'hF0; b8 = 8'h0C;
        #1;
        n_checks++; if (y8 !== 8'h03 || yall8 !== 1'b0) $display("FAIL comb_multibit: got y=%h y_all=%b, want 03 0", y8, yall8); else n_pass++;
        a8 = 8'hFF; b8 = 8'hFF;
        step();
        n_checks++; if (cnt1 !== 16'd1) $display("FAIL comb_cnt: got hit_cnt=%0d, want 1", cnt1); else n_pass++;
        in_valid = 1'b0;
        #1;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL comb_valid_drop: got out_valid=%b, want 0", ov1); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
`ifndef NOR_GATE_UNIT_COMB_OUT_EN
        test_truth_table();
        test_multibit();
        test_saturation();
        test_hold();
        test_async_reset();
`else
        test_comb_out();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nor_gate_unit.md
# nor_gate_unit

Registered, parameter-width bitwise NOR with a valid qualifier, an all-ones detect flag and a saturating hit counter. It is the clocked two-input NOR primitive for datapath glue logic. The all-inputs-zero detect it provides (`y_all`) is consumed by status and debug logic. It sits directly between a producer's `a`/`b` vectors and any downstream consumer that needs a one-cycle-registered NOR result.

## Interface
- `WIDTH`, default 1: bit width of `a`, `b` and `y`; legal range 1..64.
- `CNT_W`, default 16: width of `hit_cnt`; legal range 1..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `a` input WIDTH: first operand.
- `b` input WIDTH: second operand.
- `in_valid` input 1: qualifies `a`/`b` in the current cycle.
- `clr_cnt` input 1: synchronous clear of `hit_cnt`.
- `y` output WIDTH: bitwise NOR result, `~(a | b)`.
- `out_valid` output 1: `y` and `y_all` hold a freshly computed result.
- `y_all` output 1: high when every bit of the computed result is 1, i.e. `a` and `b` are both all-zero.
- `hit_cnt` output CNT_W: saturating count of accepted vectors with `y_all` = 1.

## Operation
- An accepted vector is a rising edge of `clk` with `in_valid` = 1.
- On an accepted vector:
  - `y` <= `~(a | b)` per bit.
  - `y_all` <= 1 if `(a | b)` == 0, else 0.
  - `out_valid` <= 1.
- On a rising edge with `in_valid` = 0:
  - `y` and `y_all` hold their last values.
  - `out_valid` <= 0.
- Single-bit truth table, with `WIDTH` = 1 and `y_all` equal to `y`:
  - 0,0 -> 1
  - 0,1 -> 0
  - 1,0 -> 0
  - 1,1 -> 0
- `hit_cnt` update priority per edge:
  1. `clr_cnt` = 1 -> 0. Clear wins over a simultaneous hit.
  2. Otherwise, an accepted vector with all-zero inputs while `hit_cnt` < 2^CNT_W-1 -> `hit_cnt` + 1.
  3. Otherwise hold. At 2^CNT_W-1 the count stays there (saturates, no wrap).
- `hit_cnt` is a registered value, updated in the same edge as `y`.

## Timing
- Reset values while `rst_n` = 0, taking effect immediately (asynchronous), with the outputs low regardless of `clk`:
  - `y` = 0
  - `y_all` = 0
  - `out_valid` = 0
  - `hit_cnt` = 0
- `y` resets to 0, not to NOR(0,0).
- Reset release is sampled at the next rising edge. The first edge with `rst_n` = 1 may accept a vector.
- Reset asserted mid-stream discards the in-flight result. No result is produced for the vector presented in the reset cycle.
- Latency (default build): 1 cycle from an accepted vector to `y`/`y_all`/`out_valid`.
- Throughput: one vector per cycle. There is no back-pressure and no ready signal; `out_valid` is a single-cycle pulse per accepted vector.
- Back-to-back accepted vectors produce back-to-back results with `out_valid` held high.

## Configuration
- Macro: `NOR_GATE_UNIT_COMB_OUT_EN`.
- Undefined (default):
  - `y`, `y_all` and `out_valid` are registered as described above.
  - Latency is 1 cycle.
- Defined:
  - `y` = `~(a | b)` and `y_all` = `((a | b) == 0)`, both combinational and continuously driven, independent of `in_valid` and `rst_n`.
  - `out_valid` = `in_valid`, combinational.
  - Latency is 0.
  - `hit_cnt` stays registered with identical counting and reset rules.

## Test plan
- Truth table: `WIDTH` = 1, default build. Drive `a`,`b` = 00, 01, 10, 11, one per cycle with `in_valid` = 1 -> `y` = 1, 0, 0, 0 one cycle later; `out_valid` = 1 throughout; `hit_cnt` = 1.
- Multi-bit: `WIDTH` = 8, `a` = 0xF0, `b` = 0x0C -> `y` = 0x03, `y_all` = 0. Then `a` = `b` = 0x00 -> `y` = 0xFF, `y_all` = 1.
- Hold/valid: accept `a` = `b` = 0, then drop `in_valid` for 3 cycles while toggling `a` = `b` = 1 -> `y` holds 1 and `out_valid` = 0 for those 3 cycles; `hit_cnt` unchanged.
- Saturation: `CNT_W` = 2, 5 accepted all-zero vectors -> `hit_cnt` goes 1, 2, 3, 3, 3. Then `clr_cnt` = 1 together with a hit -> `hit_cnt` = 0.
- Async reset: assert `rst_n` = 0 between clock edges while `y` = 1 -> `y`, `y_all`, `out_valid` and `hit_cnt` go to 0 immediately. After release, the first accepted 1,1 vector -> `y` = 0 one cycle later.
- Macro build: `NOR_GATE_UNIT_COMB_OUT_EN` defined. Change `a` from 1 to 0 with `b` = 0 mid-cycle -> `y` goes 0 to 1 with no clock edge; `out_valid` tracks `in_valid` in the same cycle.
